writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_writeback_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//
// Purpose:
//   Merges two result streams into the single register-file write port.
//   ALU results have no backpressure and always win the port. Load results
//   are sign/zero-extended at acceptance and parked in a small FIFO. The
//   FIFO head drains whenever the ALU is not writing a real register. An ALU
//   write to rd=R makes every queued load to R stale (live bit cleared). A
//   stale entry still pops in order but produces no write, so the younger
//   ALU value is never overwritten by an older load.
//
// Handshake:
//   A load transfers on a rising edge where ld_valid=1 and ld_ready=1.
//   ld_ready depends only on the registered occupancy (pend_cnt < DEPTH). It
//   never looks at the same-cycle pop, so there is no combinational path
//   from the ALU inputs to ld_ready. The ALU stream is valid-only and has
//   no ready.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data    ALU result (no backpressure)
//   ld_valid/ld_ready            load result handshake
//   ld_rd/ld_data                load destination and raw aligned word
//   ld_funct3/ld_addr_lo         load type and byte offset for extension
//   ld_err                       1-cycle pulse: accepted load had bad funct3
//   regwrite/adr_wr_reg/wr_data  registered register-file write port
//   pend_cnt                     registered number of queued load entries
// -----------------------------------------------------------------------------
module writeback_unit #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [4:0]               ld_rd,
    input  logic [31:0]              ld_data,
    input  logic [2:0]               ld_funct3,
    input  logic [1:0]               ld_addr_lo,
    output logic                     ld_err,
    output logic                     regwrite,
    output logic [4:0]               adr_wr_reg,
    output logic [31:0]              wr_data,
    output logic [$clog2(DEPTH):0]   pend_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Load types
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // ---------------------------------------------------------------------
    // Queue storage. rd/data need no reset: an entry is only ever read
    // after it has been written, and the live bits (which are reset) decide
    // whether a popped entry may write.
    // ---------------------------------------------------------------------
    logic [4:0]       q_rd   [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          regwrite_q, regwrite_d;
    logic [4:0]    adr_q, adr_d;
    logic [31:0]   data_q, data_d;
    logic          err_q, err_d;

    // ---------------------------------------------------------------------
    // Load extension
    // ---------------------------------------------------------------------
    function automatic logic [31:0] extend_load(
        input logic [2:0]  f3,
        input logic [1:0]  lo,
        input logic [31:0] w
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        // Misaligned halfwords ignore lo[0] and use the halfword lo[1] picks.
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_LB:   extend_load = {{24{b[7]}}, b};
            F3_LH:   extend_load = {{16{h[15]}}, h};
            F3_LBU:  extend_load = {24'd0, b};
            F3_LHU:  extend_load = {16'd0, h};
            default: extend_load = w;
        endcase
    endfunction

    function automatic logic funct3_ok(input logic [2:0] f3);
        funct3_ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                    (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // ---------------------------------------------------------------------
    // Control
    // ---------------------------------------------------------------------
    logic        ld_accept;
    logic        ld_rd_nz;
    logic        ld_f3_ok;
    logic        push;
    logic        alu_wr;
    logic        pop;
    logic        head_live;
    logic [31:0] ld_ext;

    assign ld_ready  = (cnt_q != FULL_CNT);
    assign ld_accept = ld_valid & ld_ready;
    assign ld_rd_nz  = (ld_rd != 5'd0);
    assign ld_f3_ok  = funct3_ok(ld_funct3);
    assign ld_ext    = extend_load(ld_funct3, ld_addr_lo, ld_data);

    // Loads to x0 vanish silently, even when their funct3 is bad.
    assign push   = ld_accept & ld_rd_nz & ld_f3_ok;
    assign err_d  = ld_accept & ld_rd_nz & ~ld_f3_ok;

    // An ALU result aimed at x0 is not a write and leaves the port free.
    assign alu_wr = alu_valid & (alu_rd != 5'd0);
    assign pop    = ~alu_wr & (cnt_q != '0);

    assign head_live = live_q[rd_ptr_q];

    // Live bits: ALU kill of matching entries, then pop, then push. Push and
    // pop never target the same slot: equal pointers mean empty (no pop) or
    // full (no push).
    always_comb begin
        live_d = live_q;
        if (alu_wr) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q_rd[i] == alu_rd) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            // A load accepted on the same edge as an ALU write to the same
            // register is already stale.
            live_d[wr_ptr_q] = ~(alu_wr && (alu_rd == ld_rd));
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Write-port select. The address/data registers only move on a real
    // write so the port holds its last value while regwrite is low.
    always_comb begin
        regwrite_d = 1'b0;
        adr_d      = adr_q;
        data_d     = data_q;
        if (alu_wr) begin
            regwrite_d = 1'b1;
            adr_d      = alu_rd;
            data_d     = alu_data;
        end else if (pop && head_live) begin
            regwrite_d = 1'b1;
            adr_d      = q_rd[rd_ptr_q];
            data_d     = q_data[rd_ptr_q];
        end
    end

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            regwrite_q <= 1'b0;
            adr_q      <= 5'd0;
            data_q     <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            live_q     <= live_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            regwrite_q <= regwrite_d;
            adr_q      <= adr_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr_q]   <= ld_rd;
            q_data[wr_ptr_q] <= ld_ext;
        end
    end

    assign regwrite   = regwrite_q;
    assign adr_wr_reg = adr_q;
    assign wr_data    = data_q;
    assign ld_err     = err_q;
    assign pend_cnt   = cnt_q;

endmodule

// File: tb/tb_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_writeback_unit
//
// Directed testbench for writeback_unit (DEPTH=2). Each scenario task drives
// its own stimulus and compares outputs #1 after the rising edge against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic        ld_err;
    logic        regwrite;
    logic [4:0]  adr_wr_reg;
    logic [31:0] wr_data;
    logic [1:0]  pend_cnt;

    int checks = 0;
    int passes = 0;

    writeback_unit dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .ld_funct3  (ld_funct3),
        .ld_addr_lo (ld_addr_lo),
        .ld_err     (ld_err),
        .regwrite   (regwrite),
        .adr_wr_reg (adr_wr_reg),
        .wr_data    (wr_data),
        .pend_cnt   (pend_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        alu_valid  = 1'b0;
        alu_rd     = 5'd0;
        alu_data   = 32'd0;
        ld_valid   = 1'b0;
        ld_rd      = 5'd0;
        ld_data    = 32'd0;
        ld_funct3  = 3'b010;
        ld_addr_lo = 2'd0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic drive_ld(input logic [2:0] f3, input logic [1:0] lo,
                            input logic [4:0] rd, input logic [31:0] d);
        ld_valid   = 1'b1;
        ld_funct3  = f3;
        ld_addr_lo = lo;
        ld_rd      = rd;
        ld_data    = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        checks++;
        if ({regwrite, adr_wr_reg, wr_data, ld_err, pend_cnt} !== 41'd0)
            $display("FAIL reset_outputs got we=%0b adr=%0d data=%h err=%0b cnt=%0d want all 0",
                     regwrite, adr_wr_reg, wr_data, ld_err, pend_cnt);
        else passes++;
        checks++;
        if (ld_ready !== 1'b1) $display("FAIL reset_ld_ready got %0b want 1", ld_ready);
        else passes++;
        #2 rst = 1'b0;
        tick();
        checks++;
        if (ld_ready !== 1'b1 || regwrite !== 1'b0)
            $display("FAIL post_reset got ready=%0b we=%0b want 1/0", ld_ready, regwrite);
        else passes++;
    endtask

    task automatic test_alu();
        drive_alu(5'd5, 32'h12345678);
        tick();
        checks++;
        if ({regwrite, adr_wr_reg, wr_data} !== {1'b1, 5'd5, 32'h12345678})
            $display("FAIL alu_write got we=%0b adr=%0d data=%h want 1/5/12345678",
                     regwrite, adr_wr_reg, wr_data);
        else passes++;
        drive_idle();
        tick();
        checks++;
        if ({regwrite, adr_wr_reg, wr_data} !== {1'b0, 5'd5, 32'h12345678})
            $display("FAIL alu_one_cycle got we=%0b adr=%0d data=%h want 0/5/12345678 (hold)",
                     regwrite, adr_wr_reg, wr_data);
        else passes++;
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
        logic [1:0]  lo  [6] = '{2'd3, 2'd3, 2'd3, 2'd1, 2'd2, 2'd1};
        logic [4:0]  rd  [6] = '{5'd7, 5'd7, 5'd8, 5'd8, 5'd11, 5'd16};
        logic [31:0] din [6] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80012345,
                                 32'h80012345, 32'hCAFEF00D, 32'h12347F56};
        logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001,
                                 32'h00002345, 32'hCAFEF00D, 32'h0000007F};
        for (int i = 0; i < 6; i++) begin
            drive_ld(f3[i], lo[i], rd[i], din[i]);
            checks++;
            if (ld_ready !== 1'b1) $display("FAIL ld_ready_idle[%0d] got %0b want 1", i, ld_ready);
            else passes++;
            tick();
            drive_idle();
            checks++;
            if (regwrite !== 1'b0 || pend_cnt !== 2'd1)
                $display("FAIL ld_accept[%0d] got we=%0b cnt=%0d want 0/1", i, regwrite, pend_cnt);
            else passes++;
            tick();
            checks++;
            if ({regwrite, adr_wr_reg, wr_data} !== {1'b1, rd[i], exp[i]})
                $display("FAIL ld_ext[%0d] got we=%0b adr=%0d data=%h want 1/%0d/%h",
                         i, regwrite, adr_wr_reg, wr_data, rd[i], exp[i]);
            else passes++;
        end
        tick();
    endtask

    task automatic test_backpressure();
        drive_alu(5'd1, 32'h000000A1);
        drive_ld(3'b010, 2'd0, 5'd2, 32'h11111111);
        tick();
        checks++;
        if ({regwrite, adr_wr_reg, wr_data} !== {1'b1, 5'd1, 32'h000000A1} || pend_cnt !== 2'd1)
            $display("FAIL bp_first got we=%0b adr=%0d cnt=%0d want 1/1/1", regwrite, adr_wr_reg, pend_cnt);
        else passes++;
        drive_ld(3'b010, 2'd0, 5'd3, 32'h22222222);
        tick();
        checks++;
        if (pend_cnt !== 2'd2 || ld_ready !== 1'b0)
            $display("FAIL bp_full got cnt=%0d ready=%0b want 2/0", pend_cnt, ld_ready);
        else passes++;
        drive_ld(3'b010, 2'd0, 5'd4, 32'h33333333);
        tick();
        checks++;
        if (pend_cnt !== 2'd2 || {regwrite, adr_wr_reg} !== {1'b1, 5'd1})
            $display("FAIL bp_third_refused got cnt=%0d we=%0b adr=%0d want 2/1/1",
                     pend_cnt, regwrite, adr_wr_reg);
        else passes++;
        drive_idle();
        tick();
        checks++;
        if ({regwrite, adr_wr_reg, wr_data} !== {1'b1, 5'd2, 32'h11111111} || pend_cnt !== 2'd1)
            $display("FAIL bp_drain0 got we=%0b adr=%0d data=%h cnt=%0d want 1/2/11111111/1",
                     regwrite, adr_wr_reg, wr_data, pend_cnt);
        else passes++;
        tick();
        checks++;
        if ({regwrite, adr_wr_reg, wr_data} !== {1'b1, 5'd3, 32'h22222222} || pend_cnt !== 2'd0)
            $display("FAIL bp_drain1 got we=%0b adr=%0d data=%h cnt=%0d want 1/3/22222222/0",
                     regwrite, adr_wr_reg, wr_data, pend_cnt);
        else passes++;
        tick();
        checks++;
        if (regwrite !== 1'b0) $display("FAIL bp_empty got we=%0b want 0", regwrite);
        else passes++;
    endtask

    task automatic test_alu_kill();
        // Load to x9 queued behind ALU traffic, then killed by an ALU write to x9.
        drive_alu(5'd1, 32'h000000B1);
        drive_ld(3'b010, 2'd0, 5'd9, 32'hDEAD0009);
        tick();
        ld_valid = 1'b0;
        drive_alu(5'd9, 32'h99999999);
        tick();
        checks++;
        if ({regwrite, adr_wr_reg, wr_data} !== {1'b1, 5'd9, 32'h99999999} || pend_cnt !== 2'd1)
            $display("FAIL kill_alu got we=%0b adr=%0d data=%h cnt=%0d want 1/9/99999999/1",
                     regwrite, adr_wr_reg, wr_data, pend_cnt);
        else passes++;
        drive_idle();
        tick();
        checks++;
        if ({regwrite, adr_wr_reg, wr_data} !== {1'b0, 5'd9, 32'h99999999} || pend_cnt !== 2'd0)
            $display("FAIL kill_pop got we=%0b adr=%0d data=%h cnt=%0d want 0/9/99999999/0",
                     regwrite, adr_wr_reg, wr_data, pend_cnt);
        else passes++;
        // Same-edge kill: load and ALU to x10 together.
        drive_alu(5'd10, 32'h0000AAAA);
        drive_ld(3'b010, 2'd0, 5'd10, 32'h0000BBBB);
        tick();
        drive_idle();
        tick();
        checks++;
        if ({regwrite, adr_wr_reg, wr_data} !== {1'b0, 5'd10, 32'h0000AAAA} || pend_cnt !== 2'd0)
            $display("FAIL kill_same_edge got we=%0b adr=%0d data=%h cnt=%0d want 0/10/0000aaaa/0",
                     regwrite, adr_wr_reg, wr_data, pend_cnt);
        else passes++;
    endtask

    task automatic test_alu_rd0();
        drive_alu(5'd0, 32'hFFFF0000);
        drive_ld(3'b010, 2'd0, 5'd12, 32'h0C0C0C0C);
        tick();
        ld_valid = 1'b0;
        checks++;
        if (regwrite !== 1'b0 || pend_cnt !== 2'd1)
            $display("FAIL rd0_no_write got we=%0b cnt=%0d want 0/1", regwrite, pend_cnt);
        else passes++;
        tick();
        checks++;
        if ({regwrite, adr_wr_reg, wr_data} !== {1'b1, 5'd12, 32'h0C0C0C0C} || pend_cnt !== 2'd0)
            $display("FAIL rd0_pop got we=%0b adr=%0d data=%h cnt=%0d want 1/12/0c0c0c0c/0",
                     regwrite, adr_wr_reg, wr_data, pend_cnt);
        else passes++;
        drive_idle();
        tick();
    endtask

    task automatic test_err_rd0();
        logic [2:0] bad [3] = '{3'b110, 3'b011, 3'b111};
        for (int i = 0; i < 3; i++) begin
            drive_ld(bad[i], 2'd0, 5'd5, 32'h55555555);
            tick();
            drive_idle();
            checks++;
            if (ld_err !== 1'b1 || pend_cnt !== 2'd0)
                $display("FAIL err_pulse[%0d] got err=%0b cnt=%0d want 1/0", i, ld_err, pend_cnt);
            else passes++;
            tick();
            checks++;
            if (ld_err !== 1'b0 || regwrite !== 1'b0)
                $display("FAIL err_one_cycle[%0d] got err=%0b we=%0b want 0/0", i, ld_err, regwrite);
            else passes++;
        end
        drive_ld(3'b010, 2'd0, 5'd0, 32'h77777777);
        tick();
        drive_idle();
        checks++;
        if (ld_err !== 1'b0 || pend_cnt !== 2'd0)
            $display("FAIL ld_x0_accept got err=%0b cnt=%0d want 0/0", ld_err, pend_cnt);
        else passes++;
        tick();
        checks++;
        if (regwrite !== 1'b0 || ld_err !== 1'b0)
            $display("FAIL ld_x0_no_write got we=%0b err=%0b want 0/0", regwrite, ld_err);
        else passes++;
    endtask

    task automatic test_back_to_back();
        drive_ld(3'b010, 2'd0, 5'd13, 32'hAAAA0013);
        tick();
        checks++;
        if (pend_cnt !== 2'd1) $display("FAIL b2b_fill got cnt=%0d want 1", pend_cnt);
        else passes++;
        drive_ld(3'b101, 2'd2, 5'd14, 32'hBEEF1234);
        tick();
        checks++;
        if ({regwrite, adr_wr_reg, wr_data} !== {1'b1, 5'd13, 32'hAAAA0013} || pend_cnt !== 2'd1)
            $display("FAIL b2b_0 got we=%0b adr=%0d data=%h cnt=%0d want 1/13/aaaa0013/1",
                     regwrite, adr_wr_reg, wr_data, pend_cnt);
        else passes++;
        drive_ld(3'b000, 2'd1, 5'd15, 32'h12347F56);
        tick();
        checks++;
        if ({regwrite, adr_wr_reg, wr_data} !== {1'b1, 5'd14, 32'h0000BEEF} || pend_cnt !== 2'd1)
            $display("FAIL b2b_1 got we=%0b adr=%0d data=%h cnt=%0d want 1/14/0000beef/1",
                     regwrite, adr_wr_reg, wr_data, pend_cnt);
        else passes++;
        drive_idle();
        tick();
        checks++;
        if ({regwrite, adr_wr_reg, wr_data} !== {1'b1, 5'd15, 32'h0000007F} || pend_cnt !== 2'd0)
            $display("FAIL b2b_2 got we=%0b adr=%0d data=%h cnt=%0d want 1/15/0000007f/0",
                     regwrite, adr_wr_reg, wr_data, pend_cnt);
        else passes++;
        tick();
        checks++;
        if ({regwrite, adr_wr_reg, wr_data} !== {1'b0, 5'd15, 32'h0000007F})
            $display("FAIL b2b_hold got we=%0b adr=%0d data=%h want 0/15/0000007f",
                     regwrite, adr_wr_reg, wr_data);
        else passes++;
    endtask

    task automatic test_mid_reset();
        drive_alu(5'd1, 32'h000000C1);
        drive_ld(3'b010, 2'd0, 5'd20, 32'h20202020);
        tick();
        drive_ld(3'b010, 2'd0, 5'd21, 32'h21212121);
        tick();
        checks++;
        if (pend_cnt !== 2'd2) $display("FAIL mr_fill got cnt=%0d want 2", pend_cnt);
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({regwrite, adr_wr_reg, wr_data, ld_err, pend_cnt} !== 41'd0 || ld_ready !== 1'b1)
            $display("FAIL mr_async got we=%0b adr=%0d data=%h cnt=%0d ready=%0b want 0/0/0/0/1",
                     regwrite, adr_wr_reg, wr_data, pend_cnt, ld_ready);
        else passes++;
        drive_idle();
        tick();
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (regwrite !== 1'b0 || pend_cnt !== 2'd0)
                $display("FAIL mr_quiet[%0d] got we=%0b cnt=%0d want 0/0", i, regwrite, pend_cnt);
            else passes++;
        end
        drive_alu(5'd6, 32'h66666666);
        tick();
        drive_idle();
        checks++;
        if ({regwrite, adr_wr_reg, wr_data} !== {1'b1, 5'd6, 32'h66666666})
            $display("FAIL mr_new_traffic got we=%0b adr=%0d data=%h want 1/6/66666666",
                     regwrite, adr_wr_reg, wr_data);
        else passes++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_alu();
        test_load_ext();
        test_backpressure();
        test_alu_kill();
        test_alu_rd0();
        test_err_rd0();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
